// File: rtl/ff_bank_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ff_bank_seq
//
// Sequencer that operates an external bank of WIDTH D flip-flops on behalf of
// two requesters (A and B). Each operation runs the fixed sequence
//   IDLE -> GRANT -> SETUP (SETUP cycles) -> STROBE (PW cycles)
//        -> RECOVER -> DONE -> IDLE
// The bank's D inputs, clock, active-low preset and active-low clear are all
// driven from registers, so every strobe is glitch-free. The bank's Q outputs
// are captured at the end of RECOVER and checked against the value the
// operation should have produced.
//
// Parameters
//   WIDTH : number of flip-flops in the bank
//   SETUP : cycles ff_d is held stable before the strobe (>= 1)
//   PW    : strobe pulse width in cycles (>= 1)
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   req_a/req_b            : level requests from requester A / B
//   op_a/op_b              : opcode 00 LOAD, 01 CLEAR, 10 PRESET, 11 READ
//   data_a/data_b          : LOAD data
//   gnt_a/gnt_b            : one-cycle grant pulse to the winner
//   done_a/done_b          : one-cycle completion pulse to the served side
//   busy                   : high whenever the sequencer is not idle
//   rdata                  : bank contents captured at completion
//   mismatch               : readback differed from the expected contents
//   ff_d, ff_clk           : bank D inputs and common clock (rising edge loads)
//   ff_sb, ff_rb           : bank common active-low preset / clear
//   ff_q                   : bank Q outputs
// ---------------------------------------------------------------------------
module ff_bank_seq #(
   parameter int WIDTH = 8,
   parameter int SETUP = 1,
   parameter int PW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [1:0]       op_a,
   input  logic [1:0]       op_b,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic             busy,
   output logic [WIDTH-1:0] rdata,
   output logic             mismatch,
   output logic [WIDTH-1:0] ff_d,
   output logic             ff_clk,
   output logic             ff_sb,
   output logic             ff_rb,
   input  logic [WIDTH-1:0] ff_q
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_SETUP,
      ST_STROBE,
      ST_RECOVER,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'b00,
      OP_CLEAR  = 2'b01,
      OP_PRESET = 2'b10,
      OP_READ   = 2'b11
   } op_t;

   // One counter serves both the SETUP and STROBE intervals.
   localparam int CNT_MAX = (SETUP > PW) ? SETUP : PW;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP - 1);
   localparam logic [CNT_W-1:0] PW_LAST    = CNT_W'(PW - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   op_t              op_l;
   logic [WIDTH-1:0] data_l;
   logic             srv_b;     // 1 when requester B owns the current operation
   logic             prefer_a;  // round-robin pointer: A wins the next tie

   logic             pick_b;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_data;

   // Readback check: compare against what the operation should have left in
   // the bank. READ has no expectation, so it always clears the flag.
   function automatic logic check_mismatch(input op_t              op,
                                           input logic [WIDTH-1:0] q,
                                           input logic [WIDTH-1:0] d);
      logic res;
      case (op)
         OP_LOAD:   res = (q != d);
         OP_CLEAR:  res = (q != '0);
         OP_PRESET: res = (q != '1);
         default:   res = 1'b0;
      endcase
      return res;
   endfunction

   // Strobe pattern {ff_clk, ff_sb, ff_rb} asserted for an opcode during
   // STROBE. Only one strobe is ever active; READ leaves all inactive.
   function automatic logic [2:0] strobe_pattern(input op_t op);
      logic [2:0] pat;
      case (op)
         OP_LOAD:   pat = 3'b111;
         OP_CLEAR:  pat = 3'b010;
         OP_PRESET: pat = 3'b001;
         default:   pat = 3'b011;
      endcase
      return pat;
   endfunction

   // Round-robin arbitration: a lone request wins; on a tie the side that was
   // not served last wins.
   always_comb begin
      pick_b   = req_b && (!req_a || !prefer_a);
      sel_op   = pick_b ? op_b   : op_a;
      sel_data = pick_b ? data_b : data_a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         gnt_a    <= 1'b0;
         gnt_b    <= 1'b0;
         done_a   <= 1'b0;
         done_b   <= 1'b0;
         ff_clk   <= 1'b0;
         ff_sb    <= 1'b1;
         ff_rb    <= 1'b1;
         ff_d     <= '0;
         rdata    <= '0;
         mismatch <= 1'b0;
         prefer_a <= 1'b1;
         op_l     <= OP_READ;
         data_l   <= '0;
         srv_b    <= 1'b0;
      end else begin
         // gnt/done are single-cycle pulses unless re-asserted below.
         gnt_a  <= 1'b0;
         gnt_b  <= 1'b0;
         done_a <= 1'b0;
         done_b <= 1'b0;

         case (state)
            // IDLE -> GRANT: requests are only sampled here.
            ST_IDLE: begin
               if (req_a || req_b) begin
                  state    <= ST_GRANT;
                  busy     <= 1'b1;
                  srv_b    <= pick_b;
                  gnt_a    <= !pick_b;
                  gnt_b    <= pick_b;
                  prefer_a <= pick_b;
                  op_l     <= op_t'(sel_op);
                  data_l   <= sel_data;
                  // ff_d only changes for LOAD; other ops keep the old value.
                  if (op_t'(sel_op) == OP_LOAD) begin
                     ff_d <= sel_data;
                  end
               end
            end

            // GRANT -> SETUP
            ST_GRANT: begin
               state <= ST_SETUP;
               cnt   <= '0;
            end

            // SETUP -> STROBE: ff_d has been stable for SETUP cycles.
            ST_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state <= ST_STROBE;
                  cnt   <= '0;
                  {ff_clk, ff_sb, ff_rb} <= strobe_pattern(op_l);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // STROBE -> RECOVER: strobe has been active for PW cycles.
            ST_STROBE: begin
               if (cnt == PW_LAST) begin
                  state  <= ST_RECOVER;
                  ff_clk <= 1'b0;
                  ff_sb  <= 1'b1;
                  ff_rb  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // RECOVER -> DONE: bank has settled; capture and check it.
            ST_RECOVER: begin
               state    <= ST_DONE;
               rdata    <= ff_q;
               mismatch <= check_mismatch(op_l, ff_q, data_l);
               done_a   <= !srv_b;
               done_b   <= srv_b;
            end

            // DONE -> IDLE
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state  <= ST_IDLE;
               busy   <= 1'b0;
               ff_clk <= 1'b0;
               ff_sb  <= 1'b1;
               ff_rb  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ff_bank_seq.sv
`timescale 1ns/1ps
// Bench for ff_bank_seq: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the bank and the arbiter.
module tb_ff_bank_seq;

   localparam int WIDTH    = 8;
   localparam int SETUP    = 1;
   localparam int PW       = 2;
   localparam int DONE_LAT = SETUP + PW + 2;   // cycles from gnt to done

   localparam logic [1:0] L_LOAD   = 2'b00;
   localparam logic [1:0] L_CLEAR  = 2'b01;
   localparam logic [1:0] L_PRESET = 2'b10;
   localparam logic [1:0] L_READ   = 2'b11;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_a, req_b;
   logic [1:0]       op_a, op_b;
   logic [WIDTH-1:0] data_a, data_b;
   logic             gnt_a, gnt_b, done_a, done_b, busy;
   logic [WIDTH-1:0] rdata;
   logic             mismatch;
   logic [WIDTH-1:0] ff_d;
   logic             ff_clk, ff_sb, ff_rb;
   logic [WIDTH-1:0] ff_q;

   always #5 clk = ~clk;

   ff_bank_seq #(.WIDTH(WIDTH), .SETUP(SETUP), .PW(PW)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .req_b(req_b),
      .op_a(op_a), .op_b(op_b),
      .data_a(data_a), .data_b(data_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b),
      .done_a(done_a), .done_b(done_b),
      .busy(busy), .rdata(rdata), .mismatch(mismatch),
      .ff_d(ff_d), .ff_clk(ff_clk), .ff_sb(ff_sb), .ff_rb(ff_rb),
      .ff_q(ff_q)
   );

   // Dual-D style bank: async active-low clear/preset, rising-edge load,
   // optional stuck-at-1 bits on the Q side.
   logic [WIDTH-1:0] bank_q;
   logic [WIDTH-1:0] stuck;
   assign ff_q = bank_q | stuck;
   always @(posedge ff_clk or negedge ff_rb or negedge ff_sb) begin
      if (!ff_rb)      bank_q <= '0;
      else if (!ff_sb) bank_q <= '1;
      else             bank_q <= ff_d;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   // Reference model state
   bit               m_prefer_a;
   logic [WIDTH-1:0] m_bank;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Bank contents an operation should leave behind.
   function automatic logic [WIDTH-1:0] op_result(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] cur);
      case (op)
         L_LOAD:   return d;
         L_CLEAR:  return '0;
         L_PRESET: return '1;
         default:  return cur;
      endcase
   endfunction

   // Continuous protocol checks and strobe-width measurement.
   int run_clk = 0, run_sb = 0, run_rb = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            run_clk = 0; run_sb = 0; run_rb = 0;
         end else begin
            chk("sb_rb_both_low", 32'(!ff_sb && !ff_rb), 0);
            chk("strobes_onehot", 32'(int'(ff_clk) + int'(!ff_sb) + int'(!ff_rb) <= 1), 1);
            chk("gnt_both", 32'(gnt_a && gnt_b), 0);
            chk("done_both", 32'(done_a && done_b), 0);
            if (ff_clk) run_clk++;
            else if (run_clk != 0) begin chk("clk_width", run_clk, PW); run_clk = 0; end
            if (!ff_sb) run_sb++;
            else if (run_sb != 0) begin chk("sb_width", run_sb, PW); run_sb = 0; end
            if (!ff_rb) run_rb++;
            else if (run_rb != 0) begin chk("rb_width", run_rb, PW); run_rb = 0; end
         end
      end
   end

   // Wait for the next grant, follow the operation to completion and check
   // winner, timing, strobes, rdata and mismatch against the model.
   task automatic txn(input bit exp_b, input logic [1:0] op, input logic [WIDTH-1:0] d,
                      input bit drop, input int exp_glat);
      int n;
      int first;
      int cnt_s;
      int bad;
      logic [2:0] pat;
      logic [2:0] exp_pat;
      logic [WIDTH-1:0] exp_r;
      bit exp_mm;
      n = 0;
      while (!(gnt_a || gnt_b) && n < 30) begin tick(); n++; end
      if (!(gnt_a || gnt_b)) begin chk("gnt_timeout", 0, 1); return; end
      chk("gnt_winner_is_b", gnt_b, exp_b);
      if (exp_glat >= 0) chk("gnt_latency", n, exp_glat);
      chk("busy_in_grant", busy, 1);
      m_prefer_a = exp_b;
      if (drop) begin
         if (exp_b) req_b = 1'b0; else req_a = 1'b0;
      end
      case (op)
         L_LOAD:   exp_pat = 3'b111;
         L_CLEAR:  exp_pat = 3'b010;
         L_PRESET: exp_pat = 3'b001;
         default:  exp_pat = 3'b011;
      endcase
      n = 0; first = -1; cnt_s = 0; bad = 0;
      while (!(done_a || done_b) && n < 30) begin
         tick(); n++;
         pat = {ff_clk, ff_sb, ff_rb};
         if (pat != 3'b011) begin
            if (first < 0) first = n;
            cnt_s++;
            if (pat != exp_pat) bad++;
         end
      end
      if (!(done_a || done_b)) begin chk("done_timeout", 0, 1); return; end
      chk("done_latency", n, DONE_LAT);
      chk("done_is_b", done_b, exp_b);
      chk("done_other_side", exp_b ? done_a : done_b, 0);
      m_bank = op_result(op, d, m_bank);
      exp_r  = m_bank | stuck;
      exp_mm = (op != L_READ) && (exp_r != m_bank);
      chk("rdata", rdata, exp_r);
      chk("mismatch", mismatch, exp_mm);
      if (op == L_READ) begin
         chk("read_strobe_cycles", cnt_s, 0);
      end else begin
         chk("strobe_first_cycle", first, SETUP + 1);
         chk("strobe_cycles", cnt_s, PW);
         chk("strobe_kind_bad", bad, 0);
      end
      tick();
      chk("done_pulse_end", 32'(done_a || done_b), 0);
      chk("busy_after_done", busy, 0);
      chk("rdata_hold", rdata, exp_r);
      chk("mismatch_hold", mismatch, exp_mm);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      int bz;
      bit ra, rb, wb;
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
      op_a = L_READ; op_b = L_READ; data_a = '0; data_b = '0;
      stuck = '0; m_bank = '0; m_prefer_a = 1'b1;

      // Reset state
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {gnt_a, gnt_b}, 0);
      chk("rst_done", {done_a, done_b}, 0);
      chk("rst_ff_clk", ff_clk, 0);
      chk("rst_ff_sb", ff_sb, 1);
      chk("rst_ff_rb", ff_rb, 1);
      chk("rst_ff_d", ff_d, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mismatch", mismatch, 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // LOAD 0xA5 from A
      req_a = 1'b1; op_a = L_LOAD; data_a = 8'hA5;
      txn(1'b0, L_LOAD, 8'hA5, 1'b1, 1);

      // Tie immediately after reset: A first, then B
      rst = 1'b1; tick(); tick();
      rst = 1'b0; m_prefer_a = 1'b1;
      req_a = 1'b1; op_a = L_LOAD; data_a = 8'h0F;
      req_b = 1'b1; op_b = L_LOAD; data_b = 8'hF0;
      txn(1'b0, L_LOAD, 8'h0F, 1'b1, 1);
      txn(1'b1, L_LOAD, 8'hF0, 1'b1, 1);
      chk("tie_final_rdata", rdata, 8'hF0);

      // CLEAR from B, then PRESET from A
      req_b = 1'b1; op_b = L_CLEAR; data_b = 8'h77;
      txn(1'b1, L_CLEAR, 8'h77, 1'b1, 1);
      req_a = 1'b1; op_a = L_PRESET; data_a = 8'h11;
      txn(1'b0, L_PRESET, 8'h11, 1'b1, 1);

      // Stuck-at-1 on bit 0: LOAD 0x3C reads 0x3D, then READ clears mismatch
      stuck = 8'h01;
      req_a = 1'b1; op_a = L_LOAD; data_a = 8'h3C;
      txn(1'b0, L_LOAD, 8'h3C, 1'b1, 1);
      chk("stuck_rdata", rdata, 8'h3D);
      chk("stuck_mismatch", mismatch, 1);
      req_b = 1'b1; op_b = L_READ;
      txn(1'b1, L_READ, 8'h00, 1'b1, 1);
      chk("read_clears_mismatch", mismatch, 0);
      stuck = '0;

      // Reset during STROBE of a LOAD
      req_a = 1'b1; op_a = L_LOAD; data_a = 8'h55;
      tick();
      chk("abort_gnt_a", gnt_a, 1);
      req_a = 1'b0;
      tick(); tick();
      chk("abort_in_strobe", ff_clk, 1);
      rst = 1'b1;
      tick();
      chk("abort_ff_clk", ff_clk, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", {done_a, done_b}, 0);
      chk("abort_rdata", rdata, 0);
      chk("abort_ff_d", ff_d, 0);
      rst = 1'b0; m_prefer_a = 1'b1;
      m_bank = 8'h55;   // rising ff_clk already loaded the bank
      dn = 0; bz = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done_a || done_b) dn++;
         if (busy) bz++;
      end
      chk("abort_no_done", dn, 0);
      chk("abort_no_resume", bz, 0);
      req_a = 1'b1; op_a = L_READ;
      txn(1'b0, L_READ, 8'h00, 1'b1, 1);
      req_b = 1'b1; op_b = L_LOAD; data_b = 8'h66;
      txn(1'b1, L_LOAD, 8'h66, 1'b1, 1);

      // A held continuously, B requests while A is busy: A, B, A
      req_a = 1'b1; op_a = L_LOAD; data_a = 8'hD1;
      tick();
      req_b = 1'b1; op_b = L_LOAD; data_b = 8'h2E;
      txn(1'b0, L_LOAD, 8'hD1, 1'b0, 0);
      txn(1'b1, L_LOAD, 8'h2E, 1'b1, 1);
      txn(1'b0, L_LOAD, 8'hD1, 1'b1, 1);
      dn = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (gnt_a || gnt_b) dn++;
      end
      chk("held_no_extra_gnt", dn, 0);

      // Randomized traffic
      for (int it = 0; it < 25; it++) begin
         ra = 1'($urandom_range(0, 1));
         rb = 1'($urandom_range(0, 1));
         if (!ra && !rb) ra = 1'b1;
         op_a = 2'($urandom_range(0, 3)); data_a = 8'($urandom);
         op_b = 2'($urandom_range(0, 3)); data_b = 8'($urandom);
         stuck = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
         req_a = ra; req_b = rb;
         wb = (ra && rb) ? !m_prefer_a : rb;
         txn(wb, wb ? op_b : op_a, wb ? data_b : data_a, 1'b1, 1);
         if (ra && rb)
            txn(!wb, wb ? op_a : op_b, wb ? data_a : data_b, 1'b1, 1);
         stuck = '0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ff_bank_seq.md
FF_BANK_SEQ -- requirements
Module: ff_bank_seq

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock `clk`; reset `rst`, synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 8: number of D flip-flops in the controlled bank.
- SETUP, 1: cycles D is held stable before the strobe; legal range >=1.
- PW, 2: strobe pulse width in cycles; legal range >=1.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- req_a / req_b, in, 1: requester A / B operation request; level signal.
- op_a / op_b, in, 2: opcode; 00 LOAD, 01 CLEAR, 10 PRESET, 11 READ.
- data_a / data_b, in, WIDTH: LOAD data.
- gnt_a / gnt_b, out, 1: one-cycle grant pulse.
- done_a / done_b, out, 1: one-cycle completion pulse.
- busy, out, 1: high whenever the FSM is not in IDLE.
- rdata, out, WIDTH: bank contents captured at completion.
- mismatch, out, 1: LOAD/CLEAR/PRESET readback differed from the expected value.
- ff_d, out, WIDTH: D inputs of the bank.
- ff_clk, out, 1: common clock of the bank; rising edge loads.
- ff_sb, out, 1: common active-low preset.
- ff_rb, out, 1: common active-low clear.
- ff_q, in, WIDTH: Q outputs of the bank.

Function
REQ-004 The FSM SHALL have the states IDLE, GRANT, SETUP, STROBE, RECOVER and DONE.
REQ-005 In IDLE with any request high, the FSM SHALL move to GRANT on the next cycle; it SHALL stay in IDLE otherwise.
REQ-006 Requests SHALL be sampled only in IDLE; requests arriving while busy SHALL wait and SHALL NOT be lost while held.
REQ-007 Arbitration SHALL be round-robin: a single request wins; when both requests are high, the requester not served last wins.
REQ-008 After reset, A SHALL be treated as "not served last", so A wins the first tie.
REQ-009 In GRANT, the block SHALL:
- pulse the winner's gnt for one cycle;
- latch the winner's op and data;
- drive ff_d with the data for LOAD, or hold ff_d at its previous value otherwise.
REQ-010 In SETUP, the block SHALL remain for exactly SETUP cycles with ff_d stable and all strobes inactive.
REQ-011 In STROBE, the block SHALL remain for exactly PW cycles, asserting for the whole interval:
- LOAD: ff_clk=1.
- CLEAR: ff_rb=0.
- PRESET: ff_sb=0.
- READ: no strobe.
REQ-012 In RECOVER, the block SHALL spend one cycle with all strobes inactive (ff_clk=0, ff_sb=1, ff_rb=1), with ff_d held.
REQ-013 The block SHALL register ff_q into rdata at the end of the RECOVER cycle.
REQ-014 In DONE, the block SHALL, for one cycle:
- pulse the served requester's done;
- present rdata valid;
- update mismatch: set if rdata differs from the latched data (LOAD), all-zeros (CLEAR) or all-ones (PRESET); cleared for READ.
REQ-015 From DONE the FSM SHALL return to IDLE; rdata and mismatch SHALL hold until the next DONE.
REQ-016 Latency SHALL be: req high in IDLE at cycle 0 -> gnt at cycle 1 -> done at cycle 1+SETUP+PW+2.
- With the defaults, this is done at cycle 6.
REQ-017 ff_sb and ff_rb SHALL never be low in the same cycle.
REQ-018 At most one of ff_clk, ~ff_sb and ~ff_rb SHALL be active in any cycle.
REQ-019 All outputs SHALL be registered; strobes SHALL be glitch-free.
REQ-020 A req held high through done SHALL be treated as a new request.
- The held requester re-enters arbitration in IDLE.
- Under the round-robin rule it yields to a pending request from the other side.
REQ-021 gnt and done pulses SHALL only ever go to the requester being served.

Reset
REQ-022 On a clock edge with rst=1, the block SHALL force:
- state IDLE, busy=0;
- gnt_a=gnt_b=done_a=done_b=0;
- ff_clk=0, ff_sb=1, ff_rb=1, ff_d=0;
- rdata=0, mismatch=0;
- round-robin pointer to favour A.
REQ-023 Reset during any state SHALL abort the operation.
- Strobes deassert on the reset edge.
- No done is issued for the aborted operation.
- The operation is not resumed after reset.
REQ-024 Reset SHALL take precedence over all requests in the same cycle.

Verification
REQ-025 The bench SHALL cover: LOAD from A, data_a=0xA5, bank modelled by the team's dual-D chip model.
- Expected: gnt_a at cycle 1; ff_clk=1 at cycles 3-4; done_a at cycle 6; rdata=0xA5; mismatch=0.
REQ-026 The bench SHALL cover: req_a=req_b=1 immediately after reset, both with op LOAD, data_a=0x0F, data_b=0xF0.
- Expected: A served first, then B.
- Expected: final rdata=0xF0, with done_a preceding done_b.
REQ-027 The bench SHALL cover: CLEAR from B, then PRESET from A.
- Expected: rdata=0x00 then 0xFF; ff_sb/ff_rb never both 0.
- Expected: each strobe is low for exactly PW cycles.
REQ-028 The bench SHALL cover: LOAD 0x3C with the bank model forcing bit 0 stuck at 1.
- Expected: rdata=0x3D; mismatch=1.
- Expected: a subsequent READ clears mismatch to 0.
REQ-029 The bench SHALL cover: rst asserted during the STROBE state of a LOAD.
- Expected: next cycle ff_clk=0, busy=0, and no done.
- Expected: a fresh request after reset completes normally.
REQ-030 The bench SHALL cover: req_a held high continuously while req_b pulses during a busy interval.
- Expected: grants alternate A, B, A.
- Expected: no request is lost.
